// File: rtl/gc_response_rx.sv
// gc_response_rx: samples and decodes the GameCube controller's 64-bit status response
module gc_response_rx #(
  parameter int CLKS_PER_US    = 27,
  parameter int ARM_TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        GC_data,
  input  logic        GC_enable,
  output logic [63:0] frame,
  output logic [15:0] buttons,
  output logic [7:0]  joy_x,
  output logic [7:0]  joy_y,
  output logic [7:0]  c_x,
  output logic [7:0]  c_y,
  output logic [7:0]  trig_l,
  output logic [7:0]  trig_r,
  output logic        frame_valid,
  output logic        rx_error,
  output logic [1:0]  err_code,
  output logic        busy
);
  localparam logic [15:0] T2 = 16'(2 * CLKS_PER_US);
  localparam logic [15:0] T4 = 16'(4 * CLKS_PER_US);
  localparam logic [15:0] TA = 16'(ARM_TIMEOUT_US * CLKS_PER_US);
  typedef enum logic [2:0] {IDLE, ARMED, LOW, HIGH, STOP_LOW, STOP_HIGH} state_t;
  state_t st, st_n;
  logic d_s1, d_s2, d_prev, en_r, en_d;
  logic [15:0] cnt, cnt_n, cn;
  logic [6:0] bc, bc_n;
  logic [63:0] shift, sh_n, fr_n;
  logic fv_n, er_n;
  logic [1:0] ec_n, err;
  wire fall = d_prev & ~d_s2;
  wire rise = ~d_prev & d_s2;
  wire en_fall = en_d & ~en_r;
  assign cn = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign busy = st != IDLE;
  assign {buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r} = frame;
  // line synchronizer, enable register and all FSM/datapath state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
      d_prev <= 1'b1;
      en_r <= 1'b0;
      en_d <= 1'b0;
      st <= IDLE;
      cnt <= '0;
      bc <= '0;
      shift <= '0;
      frame <= '0;
      frame_valid <= 1'b0;
      rx_error <= 1'b0;
      err_code <= '0;
    end else begin
      d_s1 <= GC_data;
      d_s2 <= d_s1;
      d_prev <= d_s2;
      en_r <= GC_enable;
      en_d <= en_r;
      st <= st_n;
      cnt <= cnt_n;
      bc <= bc_n;
      shift <= sh_n;
      frame <= fr_n;
      frame_valid <= fv_n;
      rx_error <= er_n;
      err_code <= ec_n;
    end
  end
  // next state: cell widths are judged on the count including the current cycle
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    bc_n = bc;
    sh_n = shift;
    fr_n = frame;
    fv_n = 1'b0;
    er_n = 1'b0;
    ec_n = err_code;
    err = 2'd0;
    case (st)
      IDLE: if (en_fall) begin
        st_n = ARMED;
        cnt_n = '0;
        bc_n = '0;
      end
      ARMED: begin
        cnt_n = fall ? '0 : cn;
        st_n = fall ? LOW : st;
        err = (!fall && cn >= TA) ? 2'd1 : 2'd0;
      end
      LOW: begin
        cnt_n = cn;
        if (cn >= T4) err = 2'd2;
        else if (rise) begin
          sh_n = {shift[62:0], cn < T2};
          bc_n = bc + 7'd1;
          cnt_n = '0;
          st_n = HIGH;
        end
      end
      HIGH: begin
        cnt_n = fall ? '0 : cn;
        st_n = fall ? ((bc == 7'd64) ? STOP_LOW : LOW) : st;
        err = (!fall && cn >= T4) ? 2'd3 : 2'd0;
      end
      STOP_LOW: begin
        cnt_n = cn;
        err = (cn >= T2) ? 2'd2 : 2'd0;
        st_n = (cn < T2 && rise) ? STOP_HIGH : st;
      end
      STOP_HIGH: begin
        st_n = IDLE;
        fr_n = shift;
        fv_n = 1'b1;
      end
      default: st_n = IDLE;
    endcase
    if (st != IDLE && en_r) err = 2'd3;
    if (err != 2'd0) begin
      st_n = IDLE;
      er_n = 1'b1;
      ec_n = err;
      fv_n = 1'b0;
      fr_n = frame;
    end
  end
endmodule

// File: tb/tb_gc_response_rx.sv
// tb_gc_response_rx: randomized cell-width stimulus with a queued scoreboard
module tb_gc_response_rx;
  localparam int C = 27;
  logic clk = 0, reset_n = 0, GC_data = 1, GC_enable = 0;
  logic [63:0] frame;
  logic [15:0] buttons;
  logic [7:0] joy_x, joy_y, c_x, c_y, trig_l, trig_r;
  logic frame_valid, rx_error, busy;
  logic [1:0] err_code;
  gc_response_rx #(.CLKS_PER_US(C), .ARM_TIMEOUT_US(100)) dut (
    .clk(clk), .reset_n(reset_n), .GC_data(GC_data), .GC_enable(GC_enable),
    .frame(frame), .buttons(buttons), .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y),
    .trig_l(trig_l), .trig_r(trig_r), .frame_valid(frame_valid), .rx_error(rx_error),
    .err_code(err_code), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {bit err; logic [1:0] code; logic [63:0] f;} ev_t;
  ev_t q[$];
  ev_t mv;
  logic [63:0] model_frame = '0;
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(int lo, int hi);
    GC_data = 0;
    cyc(lo);
    GC_data = 1;
    cyc(hi);
  endtask
  task automatic poll();
    GC_enable = 1;
    cyc(5);
    GC_enable = 0;
    cyc(10);
  endtask
  task automatic expect_ev(bit e, logic [1:0] c);
    ev_t v;
    v.err = e;
    v.code = c;
    v.f = model_frame;
    q.push_back(v);
  endtask
  task automatic send(int nbits, int mode, logic [63:0] fixed);
    int lo[64], hi[64];
    logic [63:0] f;
    for (int i = 0; i < 64; i++) begin
      if (mode == 1) lo[i] = fixed[63-i] ? C : 3 * C;
      else if (mode == 2) lo[i] = $urandom_range(0, 1) ? 2 * C - 1 : 2 * C;
      else lo[i] = $urandom_range(0, 1) ? $urandom_range(5, 2 * C - 1) : $urandom_range(2 * C, 4 * C - 1);
      hi[i] = (mode == 1) ? 4 * C - lo[i] : $urandom_range(20, 60);
      f[63-i] = lo[i] < 2 * C;
    end
    if (nbits == 64) begin
      model_frame = f;
      expect_ev(0, 0);
    end
    for (int i = 0; i < nbits; i++) pulse(lo[i], hi[i]);
    if (nbits == 64) pulse(C, 20);
  endtask
  initial forever begin
    @(negedge clk);
    if (frame_valid || rx_error) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event frame_valid=%b rx_error=%b expected=none", frame_valid, rx_error);
      end else begin
        mv = q.pop_front();
        chk("rx_error", 64'(rx_error), 64'(mv.err));
        chk("frame_valid", 64'(frame_valid), 64'(!mv.err));
        if (mv.err) chk("err_code", 64'(err_code), 64'(mv.code));
        chk("frame", frame, mv.f);
        chk("fields", {buttons, joy_x, joy_y, c_x, c_y, trig_l, trig_r}, mv.f);
      end
    end
  end
  initial begin
    cyc(3);
    chk("reset_frame", frame, 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_err_code", 64'(err_code), 0);
    chk("reset_pulses", 64'({frame_valid, rx_error}), 0);
    reset_n = 1;
    cyc(3);
    poll();
    send(64, 1, 64'h0080_8080_8080_1A2B);
    cyc(40);
    chk("busy_after_frame", 64'(busy), 0);
    chk("fixed_buttons", 64'(buttons), 64'h0080);
    chk("fixed_trig", 64'({joy_x, trig_l, trig_r}), 64'h801A2B);
    repeat (3) begin
      poll();
      send(64, 0, '0);
      cyc(30);
    end
    poll();
    send(64, 2, '0);
    cyc(30);
    poll();
    expect_ev(1, 1);
    cyc(2800);
    poll();
    expect_ev(1, 2);
    send(10, 0, '0);
    GC_data = 0;
    cyc(122);
    GC_data = 1;
    cyc(5);
    chk("busy_after_low_abort", 64'(busy), 0);
    cyc(20);
    poll();
    expect_ev(1, 3);
    send(40, 0, '0);
    cyc(150);
    poll();
    expect_ev(1, 3);
    send(20, 0, '0);
    GC_data = 0;
    cyc(10);
    GC_enable = 1;
    cyc(4);
    chk("busy_after_enable_abort", 64'(busy), 0);
    GC_data = 1;
    cyc(20);
    poll();
    send(30, 0, '0);
    GC_data = 0;
    cyc(10);
    #1 reset_n = 0;
    #1;
    chk("midreset_frame", frame, 0);
    chk("midreset_busy", 64'(busy), 0);
    chk("midreset_err_code", 64'(err_code), 0);
    model_frame = '0;
    cyc(2);
    GC_data = 1;
    reset_n = 1;
    cyc(5);
    poll();
    send(64, 0, '0);
    for (int i = 0; i < 1000 && q.size() != 0; i++) cyc(1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_events actual=%0d expected=0", q.size());
    end
    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
